fetch_controller: RTL and testbench
===================================

Name: fetch_controller

Overview:
Sequencer for the instruction memory (IM) read and write ports. In LOAD mode it streams a program image into the IM write port. In RUN mode it drives the PC, issues IM reads with 1-cycle latency, and presents instructions to decode over a valid/ready handshake, with backpressure and branch redirect. It sits between the program loader / front-end control and the IM, directly ahead of decode.

Parameters:
ADDRESS_WIDTH, 10, IM read address (word index) width; PC width.
DATA_WIDTH, 32, instruction width (IPC = 1).
RESET_PC, 0, PC value after reset and on every IDLE->RUN entry.
LOAD_DEPTH, 64, max words per load burst; fixed by the 6-bit IM write address.

Ports:
clk  in  1  clock; all state on posedge.
rst  in  1  reset, asynchronous, active-high.
run_start  in  1  pulse: IDLE->RUN.
run_stop  in  1  pulse: RUN->DRAIN.
load_start  in  1  pulse: IDLE->LOAD.
load_valid  in  1  loader word valid.
load_data  in  32  loader word.
load_last  in  1  marks the final word of the burst (qualified by load_valid).
load_ready  out  1  controller accepts a loader word.
load_done  out  1  1-cycle pulse when LOAD ends.
im_ce  out  1  IM read enable.
im_address  out  ADDRESS_WIDTH  IM read address.
im_data  in  DATA_WIDTH  IM read data; valid 1 cycle after im_ce and held while im_ce=0.
im_we  out  1  IM write enable.
im_w_address  out  6  IM write address.
im_w_data  out  32  IM write data.
redirect_valid  in  1  branch/jump redirect from a later stage.
redirect_pc  in  ADDRESS_WIDTH  redirect target.
inst_valid  out  1  instruction valid to decode.
inst_ready  in  1  decode accepts.
inst_data  out  DATA_WIDTH  instruction (= im_data).
inst_pc  out  ADDRESS_WIDTH  PC of inst_data.
busy  out  1  state != IDLE.

Behaviour:
- Reset (async, any state, mid-burst or mid-fetch included): state=IDLE, pc=RESET_PC, wptr=0, valid_q=0, fetch_pc_q=0. All outputs 0.
- FSM states: IDLE, LOAD, RUN, DRAIN.
- IDLE:
  - load_start -> LOAD with wptr=0.
  - else run_start -> RUN with pc=RESET_PC.
  - Simultaneous load_start and run_start: LOAD wins.
  - redirect_valid is ignored.
- LOAD:
  - load_ready=1.
  - im_we = load_valid, combinational; im_w_address=wptr; im_w_data=load_data.
  - Each accepted word increments wptr.
  - Exit when an accepted word has load_last=1, or when wptr==LOAD_DEPTH-1 is accepted (auto-terminate, no wrap). Next state IDLE; load_done=1 for exactly the following cycle.
  - run_start and run_stop are ignored; im_ce=0.
- RUN, fetch:
  - can_issue = !valid_q || inst_ready.
  - im_address = redirect_valid ? redirect_pc : pc.
  - im_ce = can_issue || redirect_valid.
  - On each issue: fetch_pc_q<=im_address; pc<=im_address+1, wrapping 2^ADDRESS_WIDTH-1 -> 0; valid_q<=1.
  - If no issue and inst_ready: valid_q<=0.
- Outputs in RUN:
  - inst_valid = valid_q && !redirect_valid (redirect squashes the held instruction in the same cycle).
  - inst_data = im_data; inst_pc = fetch_pc_q.
- Latency and stalls:
  - Redirect costs zero bubbles: the target is on inst_* in the cycle after redirect_valid.
  - Throughput is 1 instruction/cycle while inst_ready=1.
  - Stall: inst_ready=0 with valid_q=1 gives im_ce=0. The IM holds its data, so inst_data, inst_pc and inst_valid stay stable.
- run_stop in RUN: no further issue (im_ce=0) -> DRAIN. If run_stop and redirect_valid coincide, the stop wins and the redirect is dropped.
- DRAIN:
  - im_ce=0.
  - Hold inst_valid until the handshake completes or redirect_valid squashes it, then IDLE.
  - If valid_q=0 on entry, go to IDLE the next cycle.
- im_we=0 outside LOAD. im_ce=0 outside RUN.

Decomposition:
- Package fetch_pkg:
  - FSM state enum (IDLE, LOAD, RUN, DRAIN).
  - LOAD_ADDR_WIDTH=6.
  - Default ADDRESS_WIDTH and DATA_WIDTH constants.
- No sub-module. The loader datapath and the fetch pipeline are each under 60 lines; keep them in one module with a single FSM.

Test Plan:
- Load 3 words A,B,C with load_last on C -> im_we high 3 cycles at addresses 0,1,2; load_done pulses the cycle after C; state returns to IDLE.
- Load 70 words with no load_last -> exactly 64 writes (addresses 0..63), load_done after word 63, load_ready=0 afterwards.
- run_start with RESET_PC=0, inst_ready=1 -> im_address 0,1,2,... on consecutive cycles; inst_valid from cycle 2 with inst_pc 0,1,2,... and inst_data=IM[pc].
- inst_ready=0 for 3 cycles while inst_pc=5 -> im_ce=0 for those cycles; inst_pc=5 and inst_data held; after release, the next inst_pc=6 with no skip or duplicate.
- redirect_valid with redirect_pc=0x3FF while inst_pc=7 -> inst_valid=0 in that cycle; next cycle inst_pc=0x3FF; following cycle inst_pc=0 (wrap).
- Assert rst mid-LOAD (wptr=10) and mid-RUN -> all outputs 0 immediately (asynchronous); state IDLE; the next run_start restarts from RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch controller.
//   state_t          - controller FSM states
//   LOAD_ADDR_WIDTH  - width of the IM write-port address (loader burst index)
//   DEF_*            - default widths for the IM read port and instructions
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam int LOAD_ADDR_WIDTH    = 6;
  localparam int DEF_ADDRESS_WIDTH  = 10;
  localparam int DEF_DATA_WIDTH     = 32;

endpackage

// File: rtl/fetch_controller.sv
// fetch_controller: sequences the instruction memory (IM) ports.
//   LOAD  : streams loader words into the IM write port (im_we/im_w_*),
//           ending on load_last or after the last write address.
//   RUN   : drives the PC, issues IM reads (1-cycle latency) and presents
//           instructions to decode over inst_valid/inst_ready, with stall
//           and zero-bubble branch redirect.
//   DRAIN : stops issuing and waits for the held instruction to retire.
// Ports:
//   clk, rst (async, active-high)
//   run_start, run_stop, load_start        - mode control pulses
//   load_valid/load_data/load_last/load_ready, load_done - loader side
//   im_ce/im_address/im_data               - IM read port
//   im_we/im_w_address/im_w_data           - IM write port
//   redirect_valid/redirect_pc             - redirect from a later stage
//   inst_valid/inst_ready/inst_data/inst_pc - decode side
//   busy                                   - controller not idle
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int                       DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
  parameter int                       LOAD_DEPTH    = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run_start,
  input  logic                       run_stop,
  input  logic                       load_start,
  input  logic                       load_valid,
  input  logic [31:0]                load_data,
  input  logic                       load_last,
  output logic                       load_ready,
  output logic                       load_done,
  output logic                       im_ce,
  output logic [ADDRESS_WIDTH-1:0]   im_address,
  input  logic [DATA_WIDTH-1:0]      im_data,
  output logic                       im_we,
  output logic [LOAD_ADDR_WIDTH-1:0] im_w_address,
  output logic [31:0]                im_w_data,
  input  logic                       redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0]   redirect_pc,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [DATA_WIDTH-1:0]      inst_data,
  output logic [ADDRESS_WIDTH-1:0]   inst_pc,
  output logic                       busy
);

  localparam logic [LOAD_ADDR_WIDTH-1:0] LAST_WPTR = LOAD_ADDR_WIDTH'(LOAD_DEPTH - 1);

  state_t                     state;
  logic [ADDRESS_WIDTH-1:0]   pc;
  logic [ADDRESS_WIDTH-1:0]   fetch_pc_q;
  logic [LOAD_ADDR_WIDTH-1:0] wptr;
  logic                       valid_q;
  logic                       load_done_q;

  logic                       in_load;
  logic                       in_run;
  logic                       can_issue;
  logic                       issue;
  logic [ADDRESS_WIDTH-1:0]   fetch_addr;
  logic                       load_accept;
  logic                       load_end;

  assign in_load     = (state == S_LOAD);
  assign in_run      = (state == S_RUN);

  // Loader stage: words are written straight through in the cycle they arrive.
  assign load_accept = in_load && load_valid;
  // Auto-terminate on the last write address so the pointer never wraps.
  assign load_end    = load_accept && (load_last || (wptr == LAST_WPTR));

  // Fetch issue stage: a redirect always issues, overriding the sequential PC
  // and replacing whatever instruction is currently held.
  assign can_issue   = !valid_q || inst_ready;
  assign fetch_addr  = redirect_valid ? redirect_pc : pc;
  assign issue       = in_run && !run_stop && (can_issue || redirect_valid);

  assign load_ready   = in_load;
  assign load_done    = load_done_q;
  assign im_we        = load_accept;
  assign im_w_address = in_load ? wptr : '0;
  assign im_w_data    = in_load ? load_data : '0;
  assign im_ce        = issue;
  assign im_address   = in_run ? fetch_addr : '0;

  // Present stage: the IM holds its read data while im_ce=0, so a stalled
  // instruction stays stable without a local copy.
  assign inst_valid   = valid_q && !redirect_valid;
  assign inst_data    = valid_q ? im_data : '0;
  assign inst_pc      = fetch_pc_q;
  assign busy         = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      wptr        <= '0;
      valid_q     <= 1'b0;
      fetch_pc_q  <= '0;
      load_done_q <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_start) begin
            state <= S_LOAD;
            wptr  <= '0;
          end else if (run_start) begin
            state <= S_RUN;
            pc    <= RESET_PC;
          end
        end
        S_LOAD: begin
          if (load_accept) begin
            wptr <= wptr + LOAD_ADDR_WIDTH'(1);
            if (load_end) begin
              state       <= S_IDLE;
              load_done_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (run_stop) begin
            // Stop beats redirect: the target is never fetched, and a held
            // instruction squashed by that redirect is dropped as well.
            state <= S_DRAIN;
            if (inst_ready || redirect_valid) valid_q <= 1'b0;
          end else if (issue) begin
            fetch_pc_q <= fetch_addr;
            pc         <= fetch_addr + ADDRESS_WIDTH'(1);
            valid_q    <= 1'b1;
          end else if (inst_ready) begin
            valid_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (!valid_q || inst_ready || redirect_valid) begin
            state   <= S_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: self-checking bench for fetch_controller.
// Includes a behavioural IM (write port from the DUT, 1-cycle read port) and
// a transaction-level fetch model that predicts the delivered PC stream.
module tb_fetch_controller;
  import fetch_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run_start = 1'b0, run_stop = 1'b0, load_start = 1'b0;
  logic          load_valid = 1'b0, load_last = 1'b0;
  logic [31:0]   load_data = '0;
  logic          load_ready, load_done;
  logic          im_ce, im_we;
  logic [AW-1:0] im_address;
  logic [DW-1:0] im_data;
  logic [5:0]    im_w_address;
  logic [31:0]   im_w_data;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          inst_valid, inst_ready = 1'b0;
  logic [DW-1:0] inst_data;
  logic [AW-1:0] inst_pc;
  logic          busy;

  int n_vec  = 0;
  int n_miss = 0;

  // Fetch model: next sequential PC, PC of the held instruction, held flag.
  int m_next;
  int m_held;
  bit m_full;

  always #5 clk = ~clk;

  fetch_controller #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC('0), .LOAD_DEPTH(64)
  ) dut (
    .clk(clk), .rst(rst),
    .run_start(run_start), .run_stop(run_stop), .load_start(load_start),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .load_done(load_done),
    .im_ce(im_ce), .im_address(im_address), .im_data(im_data),
    .im_we(im_we), .im_w_address(im_w_address), .im_w_data(im_w_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .busy(busy)
  );

  function automatic logic [31:0] pattern(input int a);
    return 32'hF00D_0000 ^ 32'(a) ^ (32'(a) << 20);
  endfunction

  function automatic logic [31:0] ld_word(input int i);
    return 32'h5EED_0000 + 32'(i * 7 + 1);
  endfunction

  // Expected IM contents during RUN: the low 64 words come from the 64-word load.
  function automatic logic [31:0] exp_word(input int a);
    return (a < 64) ? ld_word(a) : pattern(a);
  endfunction

  // Behavioural IM: low 64 words are writable, the rest is a fixed pattern.
  logic [31:0] img [64];
  always @(posedge clk) begin
    if (im_we) img[im_w_address] <= im_w_data;
    if (im_ce) im_data <= (im_address < 10'd64) ? img[im_address[5:0]] : pattern(int'(im_address));
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"},  64'({load_ready, load_done, im_ce, im_we, inst_valid, busy}), 64'd0);
    chk({tag, "_addr"}, 64'({im_address, im_w_address, inst_pc}), 64'd0);
    chk({tag, "_data"}, 64'({im_w_data, inst_data}), 64'd0);
  endtask

  // One RUN cycle: inputs applied, outputs compared at the falling edge, then
  // the model advances by what the rising edge will do.
  task automatic run_step(input bit rdy, input bit rd, input int rpc);
    bit exp_ce;
    int a;
    inst_ready     = rdy;
    redirect_valid = rd;
    redirect_pc    = AW'(rpc);
    @(negedge clk);
    chk("inst_valid", 64'(inst_valid), 64'(m_full && !rd));
    if (m_full && !rd) begin
      chk("inst_pc", 64'(inst_pc), 64'(m_held));
      chk("inst_data", 64'(inst_data), 64'(exp_word(m_held)));
    end
    exp_ce = !m_full || rdy || rd;
    chk("im_ce", 64'(im_ce), 64'(exp_ce));
    if (exp_ce) begin
      a = rd ? rpc : m_next;
      chk("im_address", 64'(im_address), 64'(a));
      m_held = a;
      m_next = (a + 1) % 1024;
      m_full = 1'b1;
    end
    tick();
  endtask

  task automatic start_run();
    run_start = 1'b1;
    @(negedge clk);
    chk("run_start_ce", 64'(im_ce), 64'd0);
    tick();
    run_start = 1'b0;
    m_next = 0;
    m_full = 1'b0;
    m_held = 0;
  endtask

  typedef struct {
    logic        lv;
    logic [31:0] ld;
    logic        ll;
    logic        e_we;
    logic [5:0]  e_wa;
    logic        e_rdy;
    logic        e_done;
    logic        e_busy;
  } ld_vec_t;

  ld_vec_t tbl [7];

  initial begin
    int writes;
    tbl[0] = '{1'b1, 32'hAAAA_0001, 1'b0, 1'b1, 6'd0, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 6'd1, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 32'hBBBB_0002, 1'b0, 1'b1, 6'd1, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 32'hCCCC_0003, 1'b1, 1'b1, 6'd2, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 32'hDDDD_0004, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0};

    // Reset state
    #1;
    chk_zero("reset");
    tick();
    rst = 1'b0;

    // Three-word load with load_last on the third word
    load_start = 1'b1;
    @(negedge clk);
    chk("idle_ready", 64'(load_ready), 64'd0);
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      load_valid = tbl[i].lv;
      load_data  = tbl[i].ld;
      load_last  = tbl[i].ll;
      @(negedge clk);
      chk("ld3_we", 64'(im_we), 64'(tbl[i].e_we));
      if (tbl[i].e_rdy) chk("ld3_waddr", 64'(im_w_address), 64'(tbl[i].e_wa));
      if (tbl[i].e_we) chk("ld3_wdata", 64'(im_w_data), 64'(tbl[i].ld));
      chk("ld3_ready", 64'(load_ready), 64'(tbl[i].e_rdy));
      chk("ld3_done", 64'(load_done), 64'(tbl[i].e_done));
      chk("ld3_busy", 64'(busy), 64'(tbl[i].e_busy));
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    chk("ld3_img0", 64'(img[0]), 64'h0000_0000_AAAA_0001);
    chk("ld3_img1", 64'(img[1]), 64'h0000_0000_BBBB_0002);
    chk("ld3_img2", 64'(img[2]), 64'h0000_0000_CCCC_0003);

    // 70 words, no load_last: only 64 are written
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    writes = 0;
    for (int i = 0; i < 70; i++) begin
      load_valid = 1'b1;
      load_data  = ld_word(i);
      @(negedge clk);
      chk("ld70_we", 64'(im_we), 64'(i < 64));
      if (i < 64) chk("ld70_waddr", 64'(im_w_address), 64'(i));
      chk("ld70_ready", 64'(load_ready), 64'(i < 64));
      chk("ld70_done", 64'(load_done), 64'(i == 64));
      if (im_we) writes++;
      tick();
    end
    load_valid = 1'b0;
    chk("ld70_writes", 64'(writes), 64'd64);

    // RUN: directed prefix (stream, stall at pc 5, redirect to 0x3FF at pc 7),
    // then randomized ready/redirect against the model.
    start_run();
    for (int r = 0; r < 400; r++) begin
      bit rdy;
      bit rd;
      int rpc;
      if (r < 15) begin
        rdy = !(r >= 6 && r <= 8);
        rd  = (r == 11);
        rpc = 'h3FF;
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
        rd  = ($urandom_range(0, 9) == 0);
        rpc = int'($urandom_range(0, 1023));
      end
      if (r == 7 || r == 10 || r == 11 || r == 12 || r == 13) begin
        inst_ready = rdy;
        redirect_valid = rd;
        @(negedge clk);
        case (r)
          7:  begin chk("stall_ce", 64'(im_ce), 64'd0); chk("stall_pc", 64'(inst_pc), 64'd5); end
          10: chk("after_stall_pc", 64'(inst_pc), 64'd6);
          11: begin chk("pre_redir_pc", 64'(inst_pc), 64'd7); chk("redir_squash", 64'(inst_valid), 64'd0); end
          12: chk("redir_target_pc", 64'(inst_pc), 64'h3FF);
          default: chk("wrap_pc", 64'(inst_pc), 64'd0);
        endcase
        // run_step re-samples the same cycle; clock has not advanced.
        run_step_same_cycle(rdy, rd, rpc);
      end else begin
        run_step(rdy, rd, rpc);
      end
    end

    // Stop with an instruction held under backpressure, then drain it.
    run_step(1'b1, 1'b0, 0);
    run_stop = 1'b1;
    inst_ready = 1'b0;
    @(negedge clk);
    chk("stop_ce", 64'(im_ce), 64'd0);
    chk("stop_valid", 64'(inst_valid), 64'd1);
    tick();
    run_stop = 1'b0;
    @(negedge clk);
    chk("drain_busy", 64'(busy), 64'd1);
    chk("drain_valid", 64'(inst_valid), 64'd1);
    chk("drain_ce", 64'(im_ce), 64'd0);
    chk("drain_pc", 64'(inst_pc), 64'(m_held));
    chk("drain_data", 64'(inst_data), 64'(exp_word(m_held)));
    tick();
    inst_ready = 1'b1;
    @(negedge clk);
    chk("drain_hs_valid", 64'(inst_valid), 64'd1);
    tick();
    @(negedge clk);
    chk("drain_exit_busy", 64'(busy), 64'd0);
    chk("drain_exit_valid", 64'(inst_valid), 64'd0);
    tick();

    // Asynchronous reset in the middle of a load (wptr = 10)
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      load_valid = 1'b1;
      load_data  = ld_word(i);
      tick();
    end
    load_data = ld_word(10);
    @(negedge clk);
    chk("midload_waddr", 64'(im_w_address), 64'd10);
    #2 rst = 1'b1;
    #1 chk_zero("rst_load");
    tick();
    rst = 1'b0;
    load_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_load_busy", 64'(busy), 64'd0);
    tick();

    // Asynchronous reset in the middle of RUN, then restart from RESET_PC
    start_run();
    for (int r = 0; r < 5; r++) run_step(1'b1, 1'b0, 0);
    #2 rst = 1'b1;
    #1 chk_zero("rst_run");
    tick();
    rst = 1'b0;
    start_run();
    for (int r = 0; r < 3; r++) run_step(1'b1, 1'b0, 0);
    chk("restart_next_pc", 64'(m_next), 64'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Same as run_step but for a cycle whose falling edge has already been reached.
  task automatic run_step_same_cycle(input bit rdy, input bit rd, input int rpc);
    bit exp_ce;
    int a;
    redirect_pc = AW'(rpc);
    #0;
    chk("inst_valid", 64'(inst_valid), 64'(m_full && !rd));
    if (m_full && !rd) begin
      chk("inst_pc", 64'(inst_pc), 64'(m_held));
      chk("inst_data", 64'(inst_data), 64'(exp_word(m_held)));
    end
    exp_ce = !m_full || rdy || rd;
    chk("im_ce", 64'(im_ce), 64'(exp_ce));
    if (exp_ce) begin
      a = rd ? rpc : m_next;
      chk("im_address", 64'(im_address), 64'(a));
      m_held = a;
      m_next = (a + 1) % 1024;
      m_full = 1'b1;
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, limit 100000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
